// File: rtl/arb_pkg.sv
// arb_pkg: shared sizes and FSM state type for the arbitrated transfer controller.
package arb_pkg;
   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;
   typedef enum logic [1:0] {IDLE, XFER, ACK, SETTLE} state_t;
endpackage

// File: rtl/arb_onehot_enc.sv
// arb_onehot_enc: grant vector to master index, flagging whether the grant is exactly one-hot.
module arb_onehot_enc
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] i_grant,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_onehot_ok
);
   assign o_onehot_ok = (i_grant != '0) && ((i_grant & (i_grant - 1'b1)) == '0);
   always_comb begin
      o_idx = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (i_grant[i]) o_idx = IDX_W'(i);
   end
endmodule

// File: rtl/arb_xfer_ctrl.sv
// arb_xfer_ctrl: moves one granted master's burst to the downstream port, then acks the arbiter.
// Define ARB_XFER_TIMEOUT_EN to add a stall watchdog that aborts a burst after TIMEOUT_CYC idle cycles.
module arb_xfer_ctrl
   import arb_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int LEN_W       = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                      clk,
   input  logic                      rst_an,
   input  logic [NUM_REQ-1:0]        i_m_req,
   input  logic [NUM_REQ*LEN_W-1:0]  i_m_len,
   input  logic [NUM_REQ-1:0]        i_m_valid,
   input  logic [NUM_REQ*DATA_W-1:0] i_m_data,
   output logic [NUM_REQ-1:0]        o_m_ready,
   output logic [NUM_REQ-1:0]        o_arb_req,
   input  logic [NUM_REQ-1:0]        i_grant,
   output logic                      o_ack,
   output logic                      o_s_valid,
   input  logic                      i_s_ready,
   output logic [DATA_W-1:0]         o_s_data,
   output logic                      o_s_last,
   output logic [IDX_W-1:0]          o_s_src,
   output logic                      o_busy,
   output logic                      o_xfer_timeout
);
   state_t             r_state;
   logic [LEN_W-1:0]   r_cnt;
   logic [IDX_W-1:0]   r_src;
   logic               r_ack, r_busy, r_tmo;
   logic [IDX_W-1:0]   w_idx;
   logic               w_ok, w_x, w_beat, w_tmo;

   arb_onehot_enc u_enc (.i_grant(i_grant), .o_idx(w_idx), .o_onehot_ok(w_ok));

   assign o_arb_req      = i_m_req;
   assign w_x            = (r_state == XFER);
   assign o_s_valid      = w_x && i_m_valid[r_src];
   assign o_s_data       = w_x ? i_m_data[r_src*DATA_W +: DATA_W] : '0;
   assign o_s_last       = w_x && (r_cnt == '0);
   assign o_m_ready      = w_x ? ({{(NUM_REQ-1){1'b0}}, i_s_ready} << r_src) : '0;
   assign w_beat         = o_s_valid && i_s_ready;
   assign o_s_src        = r_src;
   assign o_ack          = r_ack;
   assign o_busy         = r_busy;
   assign o_xfer_timeout = r_tmo;

`ifdef ARB_XFER_TIMEOUT_EN
   localparam int ST_W = $clog2(TIMEOUT_CYC + 1);
   logic [ST_W-1:0] r_stall;
   // Held at zero outside XFER, so it is already clear on entry.
   always_ff @(posedge clk or negedge rst_an)
      if (!rst_an) r_stall <= '0;
      else r_stall <= (!w_x || w_beat) ? '0 : r_stall + 1'b1;
   assign w_tmo = w_x && !w_beat && (r_stall == ST_W'(TIMEOUT_CYC - 1));
`else
   logic w_unused_tmo;
   assign w_unused_tmo = (TIMEOUT_CYC == 0);
   assign w_tmo        = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_src   <= '0;
         r_ack   <= 1'b0;
         r_busy  <= 1'b0;
         r_tmo   <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         r_tmo <= 1'b0;
         case (r_state)
            IDLE: if (w_ok && i_m_req[w_idx]) begin
               r_state <= XFER;
               r_src   <= w_idx;
               r_cnt   <= i_m_len[w_idx*LEN_W +: LEN_W];
               r_busy  <= 1'b1;
            end
            XFER: if (w_beat) begin
               if (r_cnt == '0) begin
                  r_state <= ACK;
                  r_ack   <= 1'b1;
               end else r_cnt <= r_cnt - 1'b1;
            end else if (w_tmo) begin
               r_state <= ACK;
               r_ack   <= 1'b1;
               r_tmo   <= 1'b1;
            end
            ACK:    r_state <= SETTLE;
            SETTLE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_arb_xfer_ctrl.sv
// tb_arb_xfer_ctrl: directed bench for arb_xfer_ctrl with a small round-robin arbiter model.
// With ARB_XFER_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYC=8 and the watchdog is exercised.
module tb_arb_xfer_ctrl;
   import arb_pkg::*;
   localparam int DW = 32;
   localparam int LW = 4;
`ifdef ARB_XFER_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 255;
`endif

   logic              clk = 0, rst_an = 0;
   logic [3:0]        m_req = 0, m_valid = 0, m_ready, arb_req, grant, grant_drv = 0, arb_grant = 0;
   logic [4*LW-1:0]   m_len = 0;
   logic [4*DW-1:0]   m_data = 0;
   logic              ack, s_valid, s_ready = 0, s_last, busy, xfer_timeout;
   logic [DW-1:0]     s_data;
   logic [1:0]        s_src, ptr = 0;
   bit                use_arb = 0;
   int                checks = 0, errors = 0;

   always #5 clk = ~clk;
   assign grant = use_arb ? arb_grant : grant_drv;

   arb_xfer_ctrl #(.DATA_W(DW), .LEN_W(LW), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_an(rst_an), .i_m_req(m_req), .i_m_len(m_len), .i_m_valid(m_valid),
      .i_m_data(m_data), .o_m_ready(m_ready), .o_arb_req(arb_req), .i_grant(grant), .o_ack(ack),
      .o_s_valid(s_valid), .i_s_ready(s_ready), .o_s_data(s_data), .o_s_last(s_last),
      .o_s_src(s_src), .o_busy(busy), .o_xfer_timeout(xfer_timeout));

   function automatic logic [3:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] j;
      for (int k = 0; k < 4; k++) begin
         j = p + 2'(k);
         if (r[j]) return 4'b1 << j;
      end
      return 4'b0;
   endfunction

   // Registered-grant arbiter: pointer advances past the acked master, grant lags by one cycle.
   always @(posedge clk) begin
      if (!use_arb) ptr <= 2'd0;
      else if (ack) ptr <= s_src + 2'd1;
      arb_grant <= rr_pick(arb_req, use_arb ? ptr : 2'd0);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_burst(input int m, input int len, input bit drive, input int stall_at,
                            input int stall_len, input logic [31:0] base,
                            output int beats, output int stalls, output int acks, output int ack_pos,
                            output int busy_cyc, output int tmos, output bit ok);
      bit pend, started;
      beats = 0; stalls = 0; acks = 0; ack_pos = 0; busy_cyc = 0; tmos = 0; ok = 1;
      pend = 0; started = 0;
      m_len[m*LW +: LW] = LW'(len);
      m_data[m*DW +: DW] = base;
      if (drive) grant_drv = 4'b1 << m;
      for (int c = 0; c < 300; c++) begin
         tick;
         if (pend) m_data[m*DW +: DW] = base + 32'(beats);
         pend = 0;
         s_ready = !(beats == stall_at && stalls < stall_len);
         #1;
         if (busy) begin
            if (!started) grant_drv = 4'b0;
            started = 1;
            busy_cyc++;
            if (s_src != 2'(m)) ok = 0;
            if (ack) begin acks++; ack_pos = busy_cyc; end
            if (xfer_timeout) begin tmos++; if (!ack) ok = 0; end
            if (s_valid) begin
               if (s_data != base + 32'(beats)) ok = 0;
               if (s_last != (beats == len)) ok = 0;
               if (m_ready != (s_ready ? 4'b1 << m : 4'b0)) ok = 0;
               if (s_ready) begin beats++; pend = 1; end
               else stalls++;
            end
         end else if (started) break;
      end
      s_ready = 1;
   endtask

   initial begin
      int b, st, a, ap, bc, tm;
      bit ok, bad;
      m_valid = 4'hF;
      m_data  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_1000};
      m_req   = 4'b1010;
      grant_drv = 4'b0010;
      repeat (2) tick;
      chk("rst_busy", busy, 0);
      chk("rst_s_valid", s_valid, 0);
      chk("rst_m_ready", m_ready, 0);
      chk("rst_ack", ack, 0);
      chk("rst_s_src", s_src, 0);
      chk("rst_s_data", s_data, 0);
      chk("arb_req_comb", arb_req, 4'b1010);
      m_req = 4'b0000; grant_drv = 0;
      rst_an = 1;
      tick;

      m_req = 4'b0100;
      run_burst(2, 3, 1, 99, 0, 32'hC0DE_0000, b, st, a, ap, bc, tm, ok);
      chk("b4_beats", b, 4);
      chk("b4_data_src_last", ok, 1);
      chk("b4_acks", a, 1);
      chk("b4_ack_pos", ap, 5);
      chk("b4_busy_cycles", bc, 6);
      chk("b4_timeout", tm, 0);

      m_req = 4'b0010;
      run_burst(1, 2, 1, 1, 5, 32'hBEEF_0000, b, st, a, ap, bc, tm, ok);
      chk("stall_beats", b, 3);
      chk("stall_cycles", st, 5);
      chk("stall_stable_ready", ok, 1);
      chk("stall_acks", a, 1);
      chk("stall_ack_pos", ap, 9);
      chk("stall_busy", bc, 10);

      m_req = 4'b0011;
      foreach (grant_drv[i]) ;
      for (int g = 0; g < 3; g++) begin
         grant_drv = (g == 0) ? 4'b0011 : (g == 1) ? 4'b0000 : 4'b0100;
         bad = 0;
         for (int c = 0; c < 4; c++) begin
            tick;
            bad |= busy | ack | s_valid | (|m_ready);
         end
         chk(g == 0 ? "idle_multihot" : g == 1 ? "idle_zero" : "idle_noreq", bad, 0);
      end
      grant_drv = 0;

      m_req = 4'b1000;
      m_len[3*LW +: LW] = 4'd7;
      m_data[3*DW +: DW] = 32'h5A5A_5A5A;
      grant_drv = 4'b1000;
      repeat (3) tick;
      chk("pre_rst_valid", s_valid, 1);
      chk("pre_rst_src", s_src, 3);
      rst_an = 0;
      #1;
      chk("mid_rst_outputs", {busy, ack, s_valid, s_last, m_ready, s_src, xfer_timeout}, 0);
      chk("mid_rst_data", s_data, 0);
      grant_drv = 0;
      tick;
      rst_an = 1;
      bad = 0;
      for (int c = 0; c < 3; c++) begin
         tick;
         bad |= busy | ack;
      end
      chk("post_rst_idle", bad, 0);
      run_burst(3, 1, 1, 99, 0, 32'h7000_0000, b, st, a, ap, bc, tm, ok);
      chk("restart_beats", b, 2);
      chk("restart_ok_acks", {ok, 8'(a)}, {1'b1, 8'd1});

`ifdef ARB_XFER_TIMEOUT_EN
      m_req = 4'b0001;
      run_burst(0, 3, 1, 0, 1000, 32'h0, b, st, a, ap, bc, tm, ok);
      chk("tmo_beats", b, 0);
      chk("tmo_stalls", st, 8);
      chk("tmo_pulse_with_ack", {ok, 8'(tm), 8'(a)}, {1'b1, 8'd1, 8'd1});
      chk("tmo_ack_pos", ap, 9);
      chk("tmo_settle_then_idle", bc, 10);
`endif

      m_req = 4'b1111;
      m_len = {4{4'd1}};
      tick;
      use_arb = 1;
      for (int n = 0; n < 5; n++) begin
         run_burst(n % 4, 1, 0, 99, 0, 32'h100 * n, b, st, a, ap, bc, tm, ok);
         chk($sformatf("rr_burst%0d_src_ok", n), {ok, 8'(b)}, {1'b1, 8'd2});
         chk($sformatf("rr_burst%0d_acks", n), a, 1);
      end
      use_arb = 0;
      m_req = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
